// File: rtl/vc_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vc_arbiter_pkg                                                             |
// | Shared encodings for the VC arbiter and the VC FIFO top.                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package vc_arbiter_pkg;

  localparam int STATE_W = 1;

  localparam logic [STATE_W-1:0] ST_INIT = 1'b0;
  localparam logic [STATE_W-1:0] ST_ARB  = 1'b1;

  localparam logic VC_SEL0 = 1'b0;
  localparam logic VC_SEL1 = 1'b1;

  localparam logic DEST_D0 = 1'b0;
  localparam logic DEST_D1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/vc_route_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vc_route_stage                                                             |
// | Captures the pop, selects the VC word and registers it into D0 or D1.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vc_route_stage #(
  parameter int BW       = 6,
  parameter int DEST_BIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vc0_rd,
  input  logic          vc1_rd,
  input  logic [BW-1:0] vc0_data,
  input  logic [BW-1:0] vc1_data,
  output logic          rd_q,
  output logic          d0_push,
  output logic          d1_push,
  output logic [BW-1:0] d0_data,
  output logic [BW-1:0] d1_data
);
  import vc_arbiter_pkg::*;

  logic          r_rd_q;
  logic          r_sel_q;
  logic          r_d0_push;
  logic          r_d1_push;
  logic [BW-1:0] r_d0_data;
  logic [BW-1:0] r_d1_data;
  logic [BW-1:0] w_word;
  logic          w_dest;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_q  <= 1'b0;
      r_sel_q <= VC_SEL0;
    end else begin
      r_rd_q  <= vc0_rd | vc1_rd;
      r_sel_q <= vc1_rd ? VC_SEL1 : VC_SEL0;
    end
  end

  // FIFO data is valid one cycle after the pop, so routing uses the delayed select.
  always_comb begin
    w_word = (r_sel_q == VC_SEL1) ? vc1_data : vc0_data;
    w_dest = w_word[DEST_BIT];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_d0_push <= 1'b0;
      r_d1_push <= 1'b0;
      r_d0_data <= '0;
      r_d1_data <= '0;
    end else begin
      r_d0_push <= r_rd_q & (w_dest == DEST_D0);
      r_d1_push <= r_rd_q & (w_dest == DEST_D1);
      if (r_rd_q && (w_dest == DEST_D0)) begin
        r_d0_data <= w_word;
      end
      if (r_rd_q && (w_dest == DEST_D1)) begin
        r_d1_data <= w_word;
      end
    end
  end

  assign rd_q    = r_rd_q;
  assign d0_push = r_d0_push;
  assign d1_push = r_d1_push;
  assign d0_data = r_d0_data;
  assign d1_data = r_d1_data;

endmodule
`default_nettype wire

// File: rtl/vc_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vc_arbiter                                                                 |
// | Strict-priority VC0/VC1 arbiter with starvation guard, routes to D0/D1.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vc_arbiter #(
  parameter int BW       = 6,
  parameter int DEST_BIT = 4,
  parameter int WEIGHT   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vc0_empty,
  input  logic          vc1_empty,
  input  logic [BW-1:0] vc0_data,
  input  logic [BW-1:0] vc1_data,
  input  logic          d0_almost_full,
  input  logic          d1_almost_full,
  output logic          vc0_rd,
  output logic          vc1_rd,
  output logic          d0_push,
  output logic          d1_push,
  output logic [BW-1:0] d0_data,
  output logic [BW-1:0] d1_data,
  output logic          idle
);
  import vc_arbiter_pkg::*;

  localparam int                 c_cnt_w  = $clog2(WEIGHT + 1);
  localparam logic [c_cnt_w-1:0] c_weight = c_cnt_w'(WEIGHT);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic               r_vc0_rd;
  logic               r_vc1_rd;
  logic               w_gnt0;
  logic               w_gnt1;
  logic               w_arb_en;
  logic               w_stall;
  logic               w_rd_q;
  logic               w_idle;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: w_state_nxt = ST_ARB;
      ST_ARB:  w_state_nxt = ST_ARB;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    w_arb_en = (r_state == ST_ARB);
    w_idle   = w_arb_en & ~w_rd_q & ~r_vc0_rd & ~r_vc1_rd & vc0_empty & vc1_empty;
  end

  // Destination is unknown before the read, so either almost-full stalls all pops.
  assign w_stall = d0_almost_full | d1_almost_full;

  always_comb begin
    w_gnt0    = 1'b0;
    w_gnt1    = 1'b0;
    w_cnt_nxt = r_cnt;
    if (w_arb_en && !w_stall) begin
      if (!vc0_empty && (vc1_empty || (r_cnt < c_weight))) begin
        w_gnt0 = 1'b1;
        if (!vc1_empty) begin
          w_cnt_nxt = (r_cnt == c_weight) ? r_cnt : r_cnt + 1'b1;
        end else begin
          w_cnt_nxt = '0;
        end
      end else if (!vc1_empty) begin
        w_gnt1    = 1'b1;
        w_cnt_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vc0_rd <= 1'b0;
      r_vc1_rd <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_vc0_rd <= w_gnt0;
      r_vc1_rd <= w_gnt1;
      r_cnt    <= w_cnt_nxt;
    end
  end

  vc_route_stage #(
    .BW       (BW),
    .DEST_BIT (DEST_BIT)
  ) u_route (
    .clk      (clk),
    .reset    (reset),
    .vc0_rd   (r_vc0_rd),
    .vc1_rd   (r_vc1_rd),
    .vc0_data (vc0_data),
    .vc1_data (vc1_data),
    .rd_q     (w_rd_q),
    .d0_push  (d0_push),
    .d1_push  (d1_push),
    .d0_data  (d0_data),
    .d1_data  (d1_data)
  );

  assign vc0_rd = r_vc0_rd;
  assign vc1_rd = r_vc1_rd;
  assign idle   = w_idle;

endmodule
`default_nettype wire
